nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencing controller that performs WIDTH-bit addition and subtraction by time-multiplexing a single `ripple_carry_adder_4` instance, one nibble per clock, least-significant nibble first. A registered carry links consecutive nibbles. Operand nibbles are selected by a `mux_84` tree indexed by a nibble counter. The block provides area-minimal wide arithmetic to the CPU datapath, with a start/busy/done handshake.

## Interface

- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and ≥ 4. N = WIDTH/4 is the nibble count.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op_sub`  in  1  0 = A+B+c_in; 1 = A−B (B inverted, initial carry 1, c_in ignored). Sampled with `start`.
- `a`  in  WIDTH  operand A, captured on the accepting edge.
- `b`  in  WIDTH  operand B, captured on the accepting edge.
- `c_in`  in  1  carry-in for add, captured on the accepting edge.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  result register.
- `c_out`  out  1  carry out of bit WIDTH−1. For subtraction, 1 means no borrow.
- `overflow`  out  1  signed two's-complement overflow.

## Operation

- **States:** IDLE, RUN, DONE. Encoded registered, no latches.
- **IDLE:**
  - If `start`=1, capture `a` into A_reg.
  - Capture B_reg = `op_sub` ? ~`b` : `b`.
  - Set carry_reg = `op_sub` ? 1 : `c_in`.
  - Set idx = 0, clear `sum`, clear `c_out` and `overflow`, go to RUN.
- **RUN, each edge:**
  - The adder inputs are A_reg[4·idx+3:4·idx], B_reg[same] and carry_reg.
  - Write the adder sum into `sum`[4·idx+3:4·idx].
  - carry_reg ← adder c_out.
  - If idx = N−1, go to DONE. Otherwise idx ← idx+1.
- **Entering DONE:**
  - `c_out` ← final adder carry.
  - `overflow` ← (A_reg[WIDTH−1] == B_reg[WIDTH−1]) && (final sum MSB ≠ A_reg[WIDTH−1]).
  - `done` ← 1.
- **DONE:** lasts exactly one cycle, then goes to IDLE. `done` returns to 0.
- **Result hold:** `sum`, `c_out` and `overflow` hold their values from DONE until the next accepted start.
- **Width rules:**
  - idx is ceil(log2 N) bits wide, minimum 1.
  - Arithmetic is modulo 2^WIDTH. No saturation.
- **Ignored starts:** `start` in RUN or DONE is ignored. It is neither queued nor restarted. Operand inputs may change freely after acceptance.
- **Reset:** `rst_n`=0 at any edge, including mid-RUN, forces IDLE, idx=0, carry_reg=0 and all outputs to 0. An in-flight operation is discarded with no `done`.
- **Reset wins:** if `rst_n`=0 and `start`=1 on the same edge, reset takes priority.

## Timing

- **Reset values:** `busy`=0, `done`=0, `sum`=0, `c_out`=0, `overflow`=0.
- **Accepting edge E0:** the edge at which `start`=1 in IDLE. `busy` rises after E0.
- **Nibble processing:** nibble k is written at edge E0+1+k, for k = 0..N−1.
- **`done`:** high for the single cycle following edge E0+N+1. For WIDTH=16, `done` is high after E0+5.
- **Back-to-back:** `busy` falls after E0+N+2, when state = IDLE. The earliest next accepting edge is E0+N+2, giving a throughput of one operation per N+2 cycles.
- **Critical path:** one 4-bit ripple (4 FA carry stages) plus operand mux plus carry register setup. No combinational path from inputs to outputs.

## Test plan

- **Add, no carry:** WIDTH=16, a=0x1234, b=0x4321, c_in=0, op_sub=0 → `sum`=0x5555, `c_out`=0, `overflow`=0. `done` pulses exactly one cycle after E0+5, and `busy` is high for 6 cycles.
- **Inter-nibble carry propagation:** a=0xFFFF, b=0x0001, c_in=0 → `sum`=0x0000, `c_out`=1, `overflow`=0. A second case with a=0x7FFF, b=0x0000, c_in=1 → `sum`=0x8000, `overflow`=1.
- **Subtraction:** op_sub=1, a=0x8000, b=0x0001 → `sum`=0x7FFF, `c_out`=1, `overflow`=1. A second case with a=0x0003, b=0x0005 → `sum`=0xFFFE, `c_out`=0, `overflow`=0. In both cases c_in=1 is ignored.
- **Start while busy:** accept a=0x0001, b=0x0001. Pulse `start` with a=0xAAAA during RUN and again during DONE → `sum`=0x0002, exactly one `done` pulse. The result then holds 0x0002 for ≥10 idle cycles.
- **Reset mid-operation:** assert `rst_n`=0 at E0+2 → next cycle all outputs are 0 and state is IDLE, with no `done` pulse. A start after release with 0x0F0F+0x00F1 → `sum`=0x1000 at E0'+5.
- **Back-to-back operations:** hold `start`=1 continuously → accepts at E0 and E0+6 (WIDTH=16). `done` pulses 6 cycles apart with correct independent results. Repeat with WIDTH=4 (N=1): `done` follows E0+2.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract unit built around a single 4-bit
// ripple-carry adder, stepping one nibble per clock, LS nibble first.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request, sampled only while idle
//   op_sub    0: a+b+c_in, 1: a-b (c_in ignored), sampled with start
//   a, b      operands, captured on the accepting edge
//   c_in      carry-in for add, captured on the accepting edge
//   busy      high from acceptance until the result pulse has passed
//   done      one-cycle result-valid pulse
//   sum       result register, held until the next accepted start
//   c_out     carry out of the MSB (subtract: 1 = no borrow)
//   overflow  signed two's-complement overflow

module ripple_carry_adder_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1] = (a_i[i] & b_i[i]) |
                    (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = c[4];

endmodule

module mux_84 (
  input  logic [7:0] d_i,
  input  logic       sel_i,
  output logic [3:0] y_o
);

  assign y_o = sel_i ? d_i[7:4] : d_i[3:0];

endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int P  = 1 << IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] a_nib, b_nib, add_s;
  logic       add_c;
  logic       last;

  // Operand select: a binary tree of 2:1 nibble muxes.
  // Level 0 holds the P leaves (padded with zeros past N);
  // each later level halves the node count, and the root
  // selects with the MSB of idx.
  for (genvar m = 0; m <= IW; m++) begin : g_lvl
    localparam int L = IW - m;

    logic [3:0] an [1<<L];
    logic [3:0] bn [1<<L];

    if (m == 0) begin : g_leaf
      for (genvar j = 0; j < P; j++) begin : g_j
        if (j < N) begin : g_op
          assign an[j] = a_q[4*j +: 4];
          assign bn[j] = b_q[4*j +: 4];
        end else begin : g_pad
          assign an[j] = '0;
          assign bn[j] = '0;
        end
      end
    end else begin : g_node
      for (genvar k = 0; k < (1 << L); k++) begin : g_k
        mux_84 u_mux_a (
          .d_i   ({g_lvl[m-1].an[2*k+1],
                   g_lvl[m-1].an[2*k]}),
          .sel_i (idx_q[IW-1-L]),
          .y_o   (an[k])
        );
        mux_84 u_mux_b (
          .d_i   ({g_lvl[m-1].bn[2*k+1],
                   g_lvl[m-1].bn[2*k]}),
          .sel_i (idx_q[IW-1-L]),
          .y_o   (bn[k])
        );
      end
    end
  end

  assign a_nib = g_lvl[IW].an[0];
  assign b_nib = g_lvl[IW].bn[0];

  ripple_carry_adder_4 u_add (
    .a_i (a_nib),
    .b_i (b_nib),
    .c_i (carry_q),
    .s_o (add_s),
    .c_o (add_c)
  );

  assign last = (idx_q == IW'(N - 1));

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : c_in;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        for (int k = 0; k < N; k++) begin
          if (idx_q == IW'(k)) sum_d[4*k +: 4] = add_s;
        end
        carry_d = add_c;
        if (!last) idx_d = idx_q + IW'(1);
      end
      S_DONE: begin
        // b_q already holds ~b for subtraction, so one
        // rule covers both operations.
        cout_d = carry_q;
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (sum_q[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: ;
    endcase
  end

  // Registered handshake outputs. busy covers the done
  // pulse cycle as well, so it drops one cycle after done
  // unless a new start is accepted on that same edge.
  always_comb begin
    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign c_out    = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl.
// Drives a WIDTH=16 and a WIDTH=4 instance against an arithmetic model.

module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        s16, sub16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, co16, ov16;
  logic [15:0] sum16;

  logic        s4, sub4, cin4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, co4, ov4;
  logic [3:0]  sum4;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .op_sub(sub16),
    .a(a16), .b(b16), .c_in(cin16), .busy(busy16),
    .done(done16), .sum(sum16), .c_out(co16),
    .overflow(ov16)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .op_sub(sub4),
    .a(a4), .b(b4), .c_in(cin4), .busy(busy4),
    .done(done4), .sum(sum4), .c_out(co4),
    .overflow(ov4)
  );

  typedef struct {
    logic        busy;
    logic        done;
    logic        ov;
    logic        co;
    logic [15:0] sum;
  } obs_t;

  typedef struct {
    bit          sub;
    logic [15:0] a;
    logic [15:0] b;
    bit          cin;
    logic [15:0] s;
    bit          co;
    bit          ov;
  } vec_t;

  // Reference: plain modular arithmetic on the operand values.
  function automatic logic [17:0] model(int w, bit sub,
      logic [15:0] a, logic [15:0] b, bit cin);
    longint unsigned m, aa, bb, full;
    logic [15:0] s;
    bit co, ov, sa, sb, ss;
    m  = (64'd1 << w) - 1;
    aa = {48'd0, a} & m;
    bb = {48'd0, b} & m;
    if (sub) full = aa + ((~bb) & m) + 1;
    else     full = aa + bb + {63'd0, cin};
    s  = 16'(full & m);
    co = ((full >> w) & 1) != 0;
    sa = ((aa >> (w - 1)) & 1) != 0;
    sb = ((bb >> (w - 1)) & 1) != 0;
    ss = ((full >> (w - 1)) & 1) != 0;
    if (sub) ov = (sa != sb) && (ss != sa);
    else     ov = (sa == sb) && (ss != sa);
    return {ov, co, s};
  endfunction

  function automatic obs_t obs(bit w4);
    obs_t o;
    if (w4) begin
      o.busy = busy4; o.done = done4;
      o.ov = ov4; o.co = co4; o.sum = {12'h0, sum4};
    end else begin
      o.busy = busy16; o.done = done16;
      o.ov = ov16; o.co = co16; o.sum = sum16;
    end
    return o;
  endfunction

  task automatic drive(input bit w4, input bit st,
      input bit sub, input logic [15:0] a,
      input logic [15:0] b, input bit cin);
    if (w4) begin
      s4 = st; sub4 = sub; a4 = a[3:0];
      b4 = b[3:0]; cin4 = cin;
    end else begin
      s16 = st; sub16 = sub; a16 = a;
      b16 = b; cin16 = cin;
    end
  endtask

  // One operation from idle; samples every negedge after the
  // accepting edge E0 (sample k follows edge E0+k).
  task automatic do_op(input bit w4, input bit sub,
      input logic [15:0] a, input logic [15:0] b,
      input bit cin, output logic [15:0] s,
      output bit co, output bit ov, output int lat,
      output int bcnt, output int dcnt);
    obs_t o;
    lat = -1; bcnt = 0; dcnt = 0;
    s = '0; co = 0; ov = 0;
    @(negedge clk);
    drive(w4, 1'b1, sub, a, b, cin);
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0)
        drive(w4, 1'b0, 1'($urandom), 16'($urandom),
              16'($urandom), 1'($urandom));
      o = obs(w4);
      if (o.busy) bcnt++;
      if (o.done) begin
        dcnt++;
        if (lat < 0) begin
          lat = k; s = o.sum; co = o.co; ov = o.ov;
        end
      end
      if (k > 0 && !o.busy) break;
    end
  endtask

  task automatic test_reset;
    obs_t o;
    rst_n = 1'b0;
    drive(0, 1'b1, 0, 16'h1234, 16'h4321, 0);
    drive(1, 1'b1, 0, 16'h0005, 16'h0003, 0);
    repeat (3) @(negedge clk);
    o = obs(0);
    checks++;
    if ({o.busy, o.done, o.co, o.ov} !== 4'b0 ||
        o.sum !== 16'h0) begin
      errors++;
      $display("FAIL reset16: got b%b d%b c%b v%b s%h want 0",
               o.busy, o.done, o.co, o.ov, o.sum);
    end
    o = obs(1);
    checks++;
    if ({o.busy, o.done, o.co, o.ov} !== 4'b0 ||
        o.sum !== 16'h0) begin
      errors++;
      $display("FAIL reset4: got b%b d%b c%b v%b s%h want 0",
               o.busy, o.done, o.co, o.ov, o.sum);
    end
    drive(0, 1'b0, 0, 16'h0, 16'h0, 0);
    drive(1, 1'b0, 0, 16'h0, 16'h0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy: got %b want 0",
               busy16);
    end
  endtask

  task automatic test_directed;
    vec_t v[5];
    logic [15:0] s;
    bit co, ov;
    int lat, bc, dc;
    v[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0,
             16'h5555, 1'b0, 1'b0};
    v[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0,
             16'h0000, 1'b1, 1'b0};
    v[2] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1,
             16'h8000, 1'b0, 1'b1};
    v[3] = '{1'b1, 16'h8000, 16'h0001, 1'b1,
             16'h7FFF, 1'b1, 1'b1};
    v[4] = '{1'b1, 16'h0003, 16'h0005, 1'b1,
             16'hFFFE, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_op(0, v[i].sub, v[i].a, v[i].b, v[i].cin,
            s, co, ov, lat, bc, dc);
      checks++;
      if (s !== v[i].s || co !== v[i].co ||
          ov !== v[i].ov) begin
        errors++;
        $display("FAIL dir%0d result: got %h c%b v%b want %h c%b v%b",
                 i, s, co, ov, v[i].s, v[i].co, v[i].ov);
      end
      checks++;
      if (lat != 5 || bc != 6 || dc != 1) begin
        errors++;
        $display("FAIL dir%0d timing: got lat%0d busy%0d done%0d want 5 6 1",
                 i, lat, bc, dc);
      end
    end
  endtask

  task automatic test_start_while_busy;
    obs_t o;
    int dc;
    logic [15:0] s;
    dc = 0; s = '0;
    @(negedge clk);
    drive(0, 1'b1, 0, 16'h0001, 16'h0001, 0);
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0 || k == 2 || k == 5)
        drive(0, 1'b0, 0, 16'hAAAA, 16'hAAAA, 0);
      if (k == 1 || k == 4)
        drive(0, 1'b1, 0, 16'hAAAA, 16'hAAAA, 0);
      o = obs(0);
      if (o.done) begin dc++; s = o.sum; end
      if (k >= 7) begin
        checks++;
        if (o.sum !== 16'h0002 || o.busy !== 1'b0) begin
          errors++;
          $display("FAIL hold k%0d: got s%h b%b want 0002 0",
                   k, o.sum, o.busy);
        end
      end
    end
    checks++;
    if (dc != 1 || s !== 16'h0002) begin
      errors++;
      $display("FAIL ignore_start: got done%0d s%h want 1 0002",
               dc, s);
    end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    int dc;
    logic [15:0] s;
    bit co, ov;
    int lat, bc, dcnt;
    dc = 0;
    @(negedge clk);
    drive(0, 1'b1, 0, 16'h1234, 16'h1111, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 0, 16'h0, 16'h0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    o = obs(0);
    checks++;
    if ({o.busy, o.done, o.co, o.ov} !== 4'b0 ||
        o.sum !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: got b%b d%b c%b v%b s%h want 0",
               o.busy, o.done, o.co, o.ov, o.sum);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done16) dc++;
    end
    checks++;
    if (dc != 0) begin
      errors++;
      $display("FAIL reset_mid done: got %0d pulses want 0", dc);
    end
    do_op(0, 0, 16'h0F0F, 16'h00F1, 0, s, co, ov,
          lat, bc, dcnt);
    checks++;
    if (s !== 16'h1000 || lat != 5 || dcnt != 1) begin
      errors++;
      $display("FAIL after_reset: got s%h lat%0d done%0d want 1000 5 1",
               s, lat, dcnt);
    end
  endtask

  task automatic test_back_to_back(input bit w4);
    vec_t v[3];
    logic [17:0] m;
    obs_t o;
    int n, w, i, exp_k;
    n = w4 ? 1 : 4;
    w = 4 * n;
    for (int j = 0; j < 3; j++) begin
      v[j].sub = 1'($urandom);
      v[j].a = 16'($urandom);
      v[j].b = 16'($urandom);
      v[j].cin = 1'($urandom);
      m = model(w, v[j].sub, v[j].a, v[j].b, v[j].cin);
      v[j].s = m[15:0]; v[j].co = m[16]; v[j].ov = m[17];
    end
    i = 0;
    @(negedge clk);
    drive(w4, 1'b1, v[0].sub, v[0].a, v[0].b, v[0].cin);
    @(posedge clk);
    for (int k = 0; k < 40 && i < 3; k++) begin
      @(negedge clk);
      o = obs(w4);
      checks++;
      if (o.busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b w%0d busy k%0d: got %b want 1",
                 w, k, o.busy);
      end
      if (o.done) begin
        exp_k = (n + 1) + i * (n + 2);
        checks++;
        if (k != exp_k || o.sum !== v[i].s ||
            o.co !== v[i].co || o.ov !== v[i].ov) begin
          errors++;
          $display("FAIL b2b w%0d op%0d: got k%0d %h c%b v%b want k%0d %h c%b v%b",
                   w, i, k, o.sum, o.co, o.ov,
                   exp_k, v[i].s, v[i].co, v[i].ov);
        end
        i++;
        if (i < 3)
          drive(w4, 1'b1, v[i].sub, v[i].a, v[i].b, v[i].cin);
        else
          drive(w4, 1'b0, 0, 16'h0, 16'h0, 0);
      end
    end
    checks++;
    if (i != 3) begin
      errors++;
      $display("FAIL b2b w%0d timeout: got %0d results want 3",
               w, i);
      drive(w4, 1'b0, 0, 16'h0, 16'h0, 0);
    end
    repeat (n + 3) @(negedge clk);
  endtask

  task automatic test_random(input bit w4, input int cnt);
    logic [17:0] m;
    logic [15:0] a, b, s;
    bit sub, cin, co, ov;
    int lat, bc, dc, n, w;
    n = w4 ? 1 : 4;
    w = 4 * n;
    for (int i = 0; i < cnt; i++) begin
      sub = 1'($urandom);
      cin = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 5 == 0) a = w4 ? 16'h0008 : 16'h8000;
      if (i % 7 == 0) b = 16'hFFFF;
      m = model(w, sub, a, b, cin);
      do_op(w4, sub, a, b, cin, s, co, ov, lat, bc, dc);
      checks++;
      if (s !== m[15:0] || co !== m[16] || ov !== m[17] ||
          lat != n + 1 || bc != n + 2 || dc != 1) begin
        errors++;
        $display("FAIL rand w%0d #%0d %s %h %h c%b: got %h c%b v%b lat%0d busy%0d done%0d want %h c%b v%b",
                 w, i, sub ? "sub" : "add", a, b, cin,
                 s, co, ov, lat, bc, dc,
                 m[15:0], m[16], m[17]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 0, 16'h0, 16'h0, 0);
    drive(1, 1'b0, 0, 16'h0, 16'h0, 0);
    test_reset;
    test_directed;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back(0);
    test_back_to_back(1);
    test_random(0, 40);
    test_random(1, 30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
